timing_sequencer: RTL and testbench
===================================

# timing_sequencer

Parametrised successor to the CPU's timing control unit. It owns the instruction cycle counter (`o_tcu`), the `o_sync` (opcode-fetch) indication and RDY stalling. It also sequences interrupts: reset, edge-triggered NMI and level-triggered maskable IRQ, presented to the decoder as a forced BRK sequence. A halt state is entered on a decoder-signalled jam. It sits between the Decoder (next-cycle value, read/write, acknowledge) and every block that consumes the cycle count.

## Interface
- `TCU_WIDTH`, default 3: width of the cycle counter; the counter ranges from 0 to 2^TCU_WIDTH-1.
- `CNT_WIDTH`, default 16: width of the free-running debug cycle counter.
- `i_clk`  in  1  single system clock; all state updates on the rising edge.
- `i_reset_n`  in  1  reset, asynchronous, active-low.
- `i_tcu_next`  in  TCU_WIDTH  decoder's requested cycle value for the next cycle; 0 = next cycle is an opcode fetch.
- `i_rw`  in  1  decoder's current-cycle direction; 1 = read.
- `i_rdy`  in  1  ready; 0 stalls read cycles only.
- `i_nmi_n`  in  1  NMI, active-low, falling-edge sensitive.
- `i_irq_n`  in  1  IRQ, active-low, level sensitive.
- `i_i_flag`  in  1  processor status I (interrupt disable) bit.
- `i_int_ack`  in  1  decoder pulse on the final cycle (vector high fetch) of a forced-BRK sequence.
- `i_halt`  in  1  decoder pulse: jam opcode decoded.
- `o_tcu`  out  TCU_WIDTH  current cycle value.
- `o_sync`  out  1  current cycle is an opcode fetch.
- `o_stall`  out  1  current cycle is frozen.
- `o_int_kind`  out  2  interrupt being serviced: 00 none, 01 reset, 10 NMI, 11 IRQ.
- `o_force_brk`  out  1  decoder substitutes opcode 0x00 for the fetched opcode.
- `o_suppress_write`  out  1  decoder forces every write cycle to a read.
- `o_nmi_pending`  out  1  NMI edge latched and not yet serviced.
- `o_cycle_count`  out  CNT_WIDTH  count of cycles that were not stalled; wraps.

## Operation
- FSM states:
  - ST_RESET: entered asynchronously while `i_reset_n`=0. Moves to ST_RUN on the first rising edge with `i_reset_n`=1.
  - ST_RUN: normal operation. Moves to ST_HALT on `i_halt`=1 when `advance`=1.
  - ST_HALT: exited only by reset.
- `advance` = (state==ST_RUN) & (`i_rdy` | ~`i_rw`). It is evaluated from the current-cycle inputs.
- `o_stall` = ~`advance`. This includes ST_RESET and ST_HALT.
- On `advance`:
  - `o_tcu` <= `i_tcu_next`.
  - `o_cycle_count` increments by 1, modulo 2^CNT_WIDTH.
- When `advance`=0, `o_tcu`, `o_cycle_count` and `o_int_kind` hold.
- `o_sync` = (state==ST_RUN) & (`o_tcu`==0).
- NMI detection:
  - `nmi_prev` samples `i_nmi_n` every cycle, including stall and halt.
  - A falling edge (`nmi_prev`=1, `i_nmi_n`=0) sets `nmi_latch`.
  - `o_nmi_pending` = `nmi_latch`.
- `irq_active` = ~`i_irq_n` & ~`i_i_flag`.
- Boundary sample: occurs when `advance`=1, `i_tcu_next`=0 and `o_int_kind`=00.
  - `o_int_kind` is loaded by priority: NMI if `nmi_latch`, else IRQ if `irq_active`, else none.
  - An IRQ released before the boundary is never taken.
- On `i_int_ack` with `advance`=1:
  - `o_int_kind` <= 00.
  - If the kind was NMI, `nmi_latch` clears. A falling edge detected in the same cycle wins, and the latch stays set.
- `o_force_brk` = (`o_int_kind` != 00).
- `o_suppress_write` = (`o_int_kind` == 01).

## Timing
- Reset values:
  - `o_tcu`=0, `o_sync`=0, `o_stall`=1.
  - `o_int_kind`=01 (reset), so `o_force_brk`=1 and `o_suppress_write`=1.
  - `o_nmi_pending`=0, `o_cycle_count`=0.
  - `nmi_prev`=1: an NMI already held low at reset release is not an edge.
- Reset release: `o_sync`=1 and `o_stall`=0 from the first cycle after the first rising edge with `i_reset_n`=1.
- `o_tcu` latency: one cycle from `i_tcu_next` when advancing.
- `o_sync`, `o_stall`, `o_force_brk` and `o_suppress_write` are combinational from the state registers and `i_rdy`/`i_rw`.
- NMI latch delay: one cycle from the edge to `o_nmi_pending`=1.
- IRQ is serviced at the first boundary sample at which it is active.
- Wrap: `o_tcu` holds whatever `i_tcu_next` supplies; no overflow checking. `o_cycle_count` wraps from all-ones to 0.
- Reset asserted mid-instruction or mid-interrupt: all state returns to reset values immediately (asynchronous).
- `i_halt` and `i_int_ack` are ignored when `advance`=0 or when not in ST_RUN.

## Test plan
- Reset, then release; decoder drives `i_tcu_next` 1..6, then 0, with `i_int_ack` on T6. Expect:
  - `o_int_kind`=01 and `o_suppress_write`=1 for 7 cycles.
  - `o_sync`=1 only on the first cycle.
  - `o_int_kind`=00 after the ack.
  - `o_cycle_count`=7.
- `i_rdy`=0 for 3 cycles during a read at `o_tcu`=2, then `i_rdy`=0 during a write cycle. Expect:
  - `o_tcu` held at 2 and `o_stall`=1 for exactly 3 cycles, with `o_cycle_count` frozen.
  - No stall on the write.
- Pulse `i_nmi_n` low for 1 cycle mid-instruction, with `i_irq_n`=0 and `i_i_flag`=0. Expect:
  - `o_nmi_pending`=1 next cycle.
  - The next boundary gives `o_int_kind`=10, not 11.
  - After the ack, the following boundary gives 11.
- `i_irq_n`=0 with `i_i_flag`=1 across a boundary: `o_int_kind` stays 00 and `o_force_brk`=0.
- New `i_nmi_n` falling edge in the same cycle as `i_int_ack` for a kind-10 sequence: `o_nmi_pending` stays 1, and the next boundary gives kind 10 again.
- `i_halt`=1 at `o_tcu`=1. Expect:
  - ST_HALT: `o_tcu` frozen at `i_tcu_next`, `o_sync`=0, `o_stall`=1 regardless of `i_rdy`.
  - Asserting `i_reset_n`=0 restores all reset values asynchronously.

Source files
------------

// File: rtl/timing_sequencer.sv
// timing_sequencer
//   Owns the instruction cycle counter, opcode-fetch indication and RDY
//   stalling, and sequences reset / NMI / IRQ entry as a forced BRK.
//   A decoder-signalled jam halts the sequencer until reset.
// Ports:
//   i_clk, i_reset_n         clock, asynchronous active-low reset
//   i_tcu_next               decoder's cycle value for the next cycle
//   i_rw                     current-cycle direction (1 = read)
//   i_rdy                    ready; 0 stalls read cycles only
//   i_nmi_n, i_irq_n         NMI (falling edge), IRQ (low level)
//   i_i_flag                 interrupt disable status bit
//   i_int_ack                final cycle of a forced-BRK sequence
//   i_halt                   jam opcode decoded
//   o_tcu, o_sync, o_stall   cycle value, opcode fetch, frozen cycle
//   o_int_kind               00 none, 01 reset, 10 NMI, 11 IRQ
//   o_force_brk              decoder substitutes opcode 0x00
//   o_suppress_write         decoder turns writes into reads
//   o_nmi_pending            NMI edge latched, not yet serviced
//   o_cycle_count            wrapping count of non-stalled cycles
module timing_sequencer #(
    parameter int TCU_WIDTH = 3,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [TCU_WIDTH-1:0] i_tcu_next,
    input  logic                 i_rw,
    input  logic                 i_rdy,
    input  logic                 i_nmi_n,
    input  logic                 i_irq_n,
    input  logic                 i_i_flag,
    input  logic                 i_int_ack,
    input  logic                 i_halt,
    output logic [TCU_WIDTH-1:0] o_tcu,
    output logic                 o_sync,
    output logic                 o_stall,
    output logic [1:0]           o_int_kind,
    output logic                 o_force_brk,
    output logic                 o_suppress_write,
    output logic                 o_nmi_pending,
    output logic [CNT_WIDTH-1:0] o_cycle_count
);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_RUN,
        ST_HALT
    } state_t;

    localparam logic [1:0] KIND_NONE  = 2'b00;
    localparam logic [1:0] KIND_RESET = 2'b01;
    localparam logic [1:0] KIND_NMI   = 2'b10;
    localparam logic [1:0] KIND_IRQ   = 2'b11;

    state_t state;
    logic   nmi_prev;
    logic   nmi_latch;
    logic   advance;
    logic   nmi_edge;
    logic   irq_active;
    logic   boundary;
    logic   ack;

    always_comb begin
        advance    = (state == ST_RUN) && (i_rdy || !i_rw);
        nmi_edge   = nmi_prev && !i_nmi_n;
        irq_active = !i_irq_n && !i_i_flag;
        ack        = advance && i_int_ack;
        // An instruction boundary only samples interrupts when no
        // interrupt sequence is already in flight.
        boundary   = advance && (i_tcu_next == '0) && (o_int_kind == KIND_NONE);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= ST_RESET;
            o_tcu         <= '0;
            o_cycle_count <= '0;
            o_int_kind    <= KIND_RESET;
            nmi_prev      <= 1'b1;
            nmi_latch     <= 1'b0;
        end else begin
            nmi_prev <= i_nmi_n;

            case (state)
                ST_RESET: state <= ST_RUN;
                ST_RUN: begin
                    if (advance) begin
                        o_tcu         <= i_tcu_next;
                        o_cycle_count <= o_cycle_count + CNT_WIDTH'(1);
                        if (i_halt)
                            state <= ST_HALT;
                    end
                end
                default: state <= ST_HALT;
            endcase

            if (ack) begin
                o_int_kind <= KIND_NONE;
            end else if (boundary) begin
                if (nmi_latch)
                    o_int_kind <= KIND_NMI;
                else if (irq_active)
                    o_int_kind <= KIND_IRQ;
            end

            // A fresh edge in the acknowledge cycle keeps the latch set.
            if (nmi_edge)
                nmi_latch <= 1'b1;
            else if (ack && (o_int_kind == KIND_NMI))
                nmi_latch <= 1'b0;
        end
    end

    always_comb begin
        o_sync           = (state == ST_RUN) && (o_tcu == '0);
        o_stall          = !advance;
        o_force_brk      = (o_int_kind != KIND_NONE);
        o_suppress_write = (o_int_kind == KIND_RESET);
        o_nmi_pending    = nmi_latch;
    end

endmodule

// File: tb/tb_timing_sequencer.sv
// tb_timing_sequencer
//   Scoreboarded bench: the stimulus task predicts every output of the
//   cycle it drives from a behavioural model and queues it; a monitor on
//   the falling clock edge pops and compares against the DUT.
module tb_timing_sequencer;

    logic        clk;
    logic        rst_n;
    logic [2:0]  tcu_next;
    logic        rw, rdy, nmi_n, irq_n, i_flag, int_ack, halt;
    logic [2:0]  tcu;
    logic        sync, stall, force_brk, suppress_write, nmi_pending;
    logic [1:0]  int_kind;
    logic [15:0] cycle_count;

    timing_sequencer #(.TCU_WIDTH(3), .CNT_WIDTH(16)) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_tcu_next       (tcu_next),
        .i_rw             (rw),
        .i_rdy            (rdy),
        .i_nmi_n          (nmi_n),
        .i_irq_n          (irq_n),
        .i_i_flag         (i_flag),
        .i_int_ack        (int_ack),
        .i_halt           (halt),
        .o_tcu            (tcu),
        .o_sync           (sync),
        .o_stall          (stall),
        .o_int_kind       (int_kind),
        .o_force_brk      (force_brk),
        .o_suppress_write (suppress_write),
        .o_nmi_pending    (nmi_pending),
        .o_cycle_count    (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int tcu;
        int sync;
        int stall;
        int kind;
        int force_brk;
        int supw;
        int pend;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: mode 0 = waiting after reset, 1 = running, 2 = halted.
    int m_mode = 0;
    int m_tcu  = 0;
    int m_cnt  = 0;
    int m_kind = 1;
    int m_pend = 0;
    int m_prev = 1;

    task automatic model_reset();
        m_mode = 0; m_tcu = 0; m_cnt = 0; m_kind = 1; m_pend = 0; m_prev = 1;
    endtask

    task automatic check(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    // Drive one cycle, predict its outputs, then advance the model.
    task automatic step(input int tn, input bit w_rw, input bit w_rdy,
                        input bit w_nmi, input bit w_irq, input bit w_if,
                        input bit w_ack, input bit w_halt, input bit w_rst);
        exp_t e;
        bit   go, edge_seen;
        @(posedge clk);
        #1;
        tcu_next = 3'(tn); rw = w_rw; rdy = w_rdy; nmi_n = w_nmi;
        irq_n = w_irq; i_flag = w_if; int_ack = w_ack; halt = w_halt;
        rst_n = w_rst;
        if (!w_rst) model_reset();
        go          = (m_mode == 1) && (w_rdy || !w_rw);
        e.tcu       = m_tcu;
        e.sync      = (m_mode == 1 && m_tcu == 0) ? 1 : 0;
        e.stall     = go ? 0 : 1;
        e.kind      = m_kind;
        e.force_brk = (m_kind != 0) ? 1 : 0;
        e.supw      = (m_kind == 1) ? 1 : 0;
        e.pend      = m_pend;
        e.cnt       = m_cnt;
        exp_q.push_back(e);
        if (w_rst) begin
            edge_seen = (m_prev == 1) && !w_nmi;
            m_prev    = w_nmi ? 1 : 0;
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (go) begin
                m_tcu = tn;
                m_cnt = (m_cnt + 1) % 65536;
                if (w_ack) begin
                    if (m_kind == 2) m_pend = 0;
                    m_kind = 0;
                end else if (tn == 0 && m_kind == 0) begin
                    if (m_pend == 1)           m_kind = 2;
                    else if (!w_irq && !w_if)  m_kind = 3;
                end
                if (w_halt) m_mode = 2;
            end
            if (edge_seen) m_pend = 1;
        end
    endtask

    // Plain read cycle shorthand for the directed part.
    task automatic rd(input int tn, input bit w_nmi, input bit w_irq,
                      input bit w_if, input bit w_ack);
        step(tn, 1'b1, 1'b1, w_nmi, w_irq, w_if, w_ack, 1'b0, 1'b1);
    endtask

    // Seven-cycle forced-BRK body starting from tcu=0, ack on T6.
    task automatic brk_seq(input bit w_irq, input bit w_if);
        for (int t = 1; t <= 6; t++) rd(t, 1'b1, w_irq, w_if, 1'b0);
        rd(0, 1'b1, w_irq, w_if, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tcu",            int'(tcu),            e.tcu);
                check("sync",           int'(sync),           e.sync);
                check("stall",          int'(stall),          e.stall);
                check("int_kind",       int'(int_kind),       e.kind);
                check("force_brk",      int'(force_brk),      e.force_brk);
                check("suppress_write", int'(suppress_write), e.supw);
                check("nmi_pending",    int'(nmi_pending),    e.pend);
                check("cycle_count",    int'(cycle_count),    e.cnt);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_n = 1'b0; tcu_next = '0; rw = 1'b1; rdy = 1'b1; nmi_n = 1'b1;
        irq_n = 1'b1; i_flag = 1'b1; int_ack = 1'b0; halt = 1'b0;

        // Reset, release, then the reset BRK sequence.
        step(0, 1, 1, 1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 1, 1, 0, 0, 1);
        brk_seq(1'b1, 1'b1);

        // Read stalls at tcu=2, then a not-ready write that must proceed.
        rd(1, 1, 1, 1, 0);
        rd(2, 1, 1, 1, 0);
        for (int k = 0; k < 3; k++) step(3, 1, 0, 1, 1, 1, 0, 0, 1);
        rd(3, 1, 1, 1, 0);
        step(4, 0, 0, 1, 1, 1, 0, 0, 1);
        rd(0, 1, 1, 1, 0);

        // NMI pulse with IRQ also active: NMI wins, then IRQ.
        rd(1, 1, 0, 0, 0);
        rd(2, 0, 0, 0, 0);
        rd(0, 1, 0, 0, 0);
        brk_seq(1'b0, 1'b0);
        rd(0, 1, 0, 0, 0);
        brk_seq(1'b1, 1'b0);

        // IRQ masked across a boundary.
        rd(1, 1, 0, 1, 0);
        rd(0, 1, 0, 1, 0);
        rd(1, 1, 0, 1, 0);

        // New NMI edge coincident with the NMI acknowledge.
        rd(2, 0, 1, 1, 0);
        rd(0, 1, 1, 1, 0);
        for (int t = 1; t <= 6; t++) rd(t, 1, 1, 1, 0);
        rd(0, 0, 1, 1, 1);
        rd(0, 0, 1, 1, 0);
        for (int t = 1; t <= 6; t++) rd(t, 1, 1, 1, 0);
        rd(0, 1, 1, 1, 1);

        // Halt at tcu=1, stays halted whatever RDY does, then async reset.
        rd(1, 1, 1, 1, 0);
        step(5, 1, 1, 1, 1, 1, 0, 1, 1);
        step(0, 1, 1, 1, 1, 1, 0, 0, 1);
        step(0, 0, 0, 1, 1, 1, 1, 1, 1);
        step(0, 1, 0, 1, 1, 1, 0, 0, 1);
        step(0, 1, 1, 1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 1, 1, 0, 0, 1);

        // Randomized phase.
        for (int c = 0; c < 3000; c++) begin
            int tn;
            bit r_rst;
            tn    = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 7));
            r_rst = ($urandom_range(0, 99) >= 2);
            step(tn, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                 ($urandom_range(0, 4) == 0) ? ~nmi_n : nmi_n,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0, r_rst);
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
